// File: rtl/ascon_serial_ctrl.sv
// Command sequencer for the bit-serial ASCON-128 core: loads key, nonce, AD and data
// MSB-first, starts the core under a watchdog and deserialises data and tag.
module ascon_serial_ctrl #(
    parameter int K         = 128,
    parameter int L         = 40,
    parameter int Y         = 104,
    parameter int START_LEN = 3,
    parameter int TIMEOUT   = 4096
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic           cmd_decrypt,
    input  logic [K-1:0]   cmd_key,
    input  logic [127:0]   cmd_nonce,
    input  logic [L-1:0]   cmd_ad,
    input  logic [Y-1:0]   cmd_data,
    output logic           res_valid,
    input  logic           res_ready,
    output logic           res_err,
    output logic [Y-1:0]   res_data,
    output logic [127:0]   res_tag,
    output logic [31:0]    run_cycles,
    output logic           busy,
    output logic           core_rst,
    output logic           keyxSI,
    output logic           noncexSI,
    output logic           associated_dataxSI,
    output logic           input_dataxSI,
    output logic           ascon_startxSI,
    output logic           decrypt,
    input  logic           output_dataxSO,
    input  logic           tagxSO,
    input  logic           ascon_readyxSO
);
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int LOAD_LEN = max2(max2(K, 128), max2(L, Y));
    localparam int CAP_LEN  = max2(Y, 128);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    typedef enum logic [3:0] {
        IDLE, CRST, LOAD, START, WAIT, SKIP, CAP, DONE, ERR
    } state_t;

    state_t         state;
    logic [31:0]    cnt;
    logic [K-1:0]   key_sh;
    logic [127:0]   nonce_sh;
    logic [L-1:0]   ad_sh;
    logic [Y-1:0]   data_sh;

    // Operand shift registers drain MSB-first and zero-fill, so shorter fields
    // naturally present 0 once they run out during the common LOAD window.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            cnt                <= '0;
            cmd_ready          <= 1'b1;
            busy               <= 1'b0;
            core_rst           <= 1'b1;
            keyxSI             <= 1'b0;
            noncexSI           <= 1'b0;
            associated_dataxSI <= 1'b0;
            input_dataxSI      <= 1'b0;
            ascon_startxSI     <= 1'b0;
            decrypt            <= 1'b0;
            res_valid          <= 1'b0;
            res_err            <= 1'b0;
            res_data           <= '0;
            res_tag            <= '0;
            run_cycles         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    core_rst <= 1'b0;
                    if (cmd_valid) begin
                        key_sh     <= cmd_key;
                        nonce_sh   <= cmd_nonce;
                        ad_sh      <= cmd_ad;
                        data_sh    <= cmd_data;
                        decrypt    <= cmd_decrypt;
                        res_data   <= '0;
                        res_tag    <= '0;
                        run_cycles <= '0;
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                        core_rst   <= 1'b1;
                        cnt        <= '0;
                        state      <= CRST;
                    end
                end
                CRST: begin
                    if (cnt == 32'd1) begin
                        core_rst           <= 1'b0;
                        keyxSI             <= key_sh[K-1];
                        noncexSI           <= nonce_sh[127];
                        associated_dataxSI <= ad_sh[L-1];
                        input_dataxSI      <= data_sh[Y-1];
                        key_sh             <= key_sh << 1;
                        nonce_sh           <= nonce_sh << 1;
                        ad_sh              <= ad_sh << 1;
                        data_sh            <= data_sh << 1;
                        cnt                <= '0;
                        state              <= LOAD;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                LOAD: begin
                    if (cnt == 32'(LOAD_LEN - 1)) begin
                        keyxSI             <= 1'b0;
                        noncexSI           <= 1'b0;
                        associated_dataxSI <= 1'b0;
                        input_dataxSI      <= 1'b0;
                        ascon_startxSI     <= 1'b1;
                        cnt                <= '0;
                        state              <= START;
                    end else begin
                        keyxSI             <= key_sh[K-1];
                        noncexSI           <= nonce_sh[127];
                        associated_dataxSI <= ad_sh[L-1];
                        input_dataxSI      <= data_sh[Y-1];
                        key_sh             <= key_sh << 1;
                        nonce_sh           <= nonce_sh << 1;
                        ad_sh              <= ad_sh << 1;
                        data_sh            <= data_sh << 1;
                        cnt                <= cnt + 32'd1;
                    end
                end
                START: begin
                    run_cycles <= sat_inc(run_cycles);
                    if (cnt == 32'(START_LEN - 1)) begin
                        ascon_startxSI <= 1'b0;
                        cnt            <= '0;
                        state          <= WAIT;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                WAIT: begin
                    // A ready seen on the last allowed cycle still wins over the watchdog.
                    run_cycles <= sat_inc(run_cycles);
                    if (ascon_readyxSO) begin
                        cnt   <= '0;
                        state <= SKIP;
                    end else if (cnt == 32'(TIMEOUT - 1)) begin
                        res_valid <= 1'b1;
                        res_err   <= 1'b1;
                        res_data  <= '0;
                        res_tag   <= '0;
                        core_rst  <= 1'b1;
                        state     <= ERR;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                SKIP: begin
                    if (cnt == 32'd1) begin
                        cnt   <= '0;
                        state <= CAP;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                CAP: begin
                    if (cnt < 32'(Y))
                        res_data <= {res_data[Y-2:0], output_dataxSO};
                    if (cnt < 32'd128)
                        res_tag <= {res_tag[126:0], tagxSO};
                    if (cnt == 32'(CAP_LEN - 1)) begin
                        res_valid <= 1'b1;
                        res_err   <= 1'b0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                DONE, ERR: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        res_err   <= 1'b0;
                        core_rst  <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ascon_serial_ctrl.sv
// Scoreboard bench for ascon_serial_ctrl with a behavioural stand-in for the serial core.
module tb_ascon_serial_ctrl;
    localparam int K         = 128;
    localparam int L         = 40;
    localparam int Y         = 104;
    localparam int START_LEN = 3;
    localparam int TIMEOUT   = 16;
    localparam int LAT       = 4;

    localparam logic [127:0] KEY_V   = 128'h6d4f8bbf60ec05a07b201d4e5b2119ac;
    localparam logic [127:0] NONCE_V = 128'h05885e606e1271b8d47a74c7b297a318;
    localparam logic [39:0]  AD_V    = 40'h4153434f4e;
    localparam logic [103:0] PT_V    = 104'h6173636f6e2d756e6963617373;
    localparam logic [103:0] CT_V    = 104'h18490112f8d5867a830748390b;
    // Core stand-in: keystream fixed to the reference vector, tag a mix of key/nonce/AD.
    localparam logic [103:0] KS_V    = PT_V ^ CT_V;
    localparam logic [127:0] TAG_V   = KEY_V ^ NONCE_V ^ {AD_V, 88'b0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmd_valid = 1'b0, cmd_ready, cmd_decrypt = 1'b0;
    logic [K-1:0]   cmd_key = '0;
    logic [127:0]   cmd_nonce = '0;
    logic [L-1:0]   cmd_ad = '0;
    logic [Y-1:0]   cmd_data = '0;
    logic res_valid, res_ready = 1'b0, res_err;
    logic [Y-1:0]   res_data;
    logic [127:0]   res_tag;
    logic [31:0]    run_cycles;
    logic busy, core_rst, keyxSI, noncexSI, associated_dataxSI, input_dataxSI;
    logic ascon_startxSI, decrypt;
    logic output_dataxSO = 1'b0, tagxSO = 1'b0, ascon_readyxSO = 1'b0;

    always #5 clk = ~clk;

    ascon_serial_ctrl #(.K(K), .L(L), .Y(Y), .START_LEN(START_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_decrypt(cmd_decrypt),
        .cmd_key(cmd_key), .cmd_nonce(cmd_nonce), .cmd_ad(cmd_ad), .cmd_data(cmd_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_err(res_err),
        .res_data(res_data), .res_tag(res_tag), .run_cycles(run_cycles), .busy(busy),
        .core_rst(core_rst), .keyxSI(keyxSI), .noncexSI(noncexSI),
        .associated_dataxSI(associated_dataxSI), .input_dataxSI(input_dataxSI),
        .ascon_startxSI(ascon_startxSI), .decrypt(decrypt),
        .output_dataxSO(output_dataxSO), .tagxSO(tagxSO), .ascon_readyxSO(ascon_readyxSO)
    );

    typedef struct {
        logic         err;
        logic         dec;
        logic [Y-1:0] data;
        logic [127:0] tag;
        logic [31:0]  cyc;
        logic [127:0] key, nonce, ad, din;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // ---------------- serial core model ----------------
    logic [127:0] key_rx = '0, nonce_rx = '0, ad_rx = '0, din_rx = '0;
    int  lcnt = 0, load_cycles = 0, crst_run = 0, crst_len = 0;
    bit  loading = 1'b0;
    bit  no_ready = 1'b0;

    always @(negedge clk) begin
        if (core_rst) begin
            crst_run++;
            lcnt    = 0;
            loading = 1'b1;
        end else begin
            if (crst_run != 0) begin
                crst_len = crst_run;
                crst_run = 0;
            end
            if (ascon_startxSI && loading) begin
                load_cycles = lcnt;
                loading     = 1'b0;
            end
            if (loading) begin
                if (lcnt < 128) begin
                    key_rx   = {key_rx[126:0], keyxSI};
                    nonce_rx = {nonce_rx[126:0], noncexSI};
                    ad_rx    = {ad_rx[126:0], associated_dataxSI};
                    din_rx   = {din_rx[126:0], input_dataxSI};
                end
                lcnt++;
            end
        end
    end

    initial begin
        logic [Y-1:0] out_v;
        logic [127:0] tag_v;
        forever begin
            @(negedge clk);
            if (ascon_startxSI) begin
                do @(negedge clk); while (ascon_startxSI);
                if (!no_ready) begin
                    repeat (LAT) @(negedge clk);
                    ascon_readyxSO = 1'b1;
                    out_v = din_rx[127 -: Y] ^ KS_V;
                    tag_v = key_rx ^ nonce_rx ^ ad_rx;
                    @(negedge clk);
                    ascon_readyxSO = 1'b0;
                    @(negedge clk);
                    for (int j = 0; j < 128; j++) begin
                        @(negedge clk);
                        output_dataxSO = (j < Y) ? out_v[Y-1-j] : 1'b0;
                        tagxSO         = tag_v[127-j];
                    end
                    @(negedge clk);
                    output_dataxSO = 1'b0;
                    tagxSO         = 1'b0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    exp_t cur;
    bit   have_cur = 1'b0;
    bit   prev_v = 1'b0;
    int   accepts = 0;
    int   ready_busy_viol = 0;

    always begin
        @(negedge clk);
        #1;
        if (cmd_valid && cmd_ready && !rst) accepts++;
        if (busy == cmd_ready) ready_busy_viol++;
        if (res_valid && !prev_v) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got res_valid=1, required no result");
            end else begin
                cur = sb.pop_front();
                have_cur = 1'b1;
                check("res_err", res_err, cur.err);
                check("res_data", res_data, cur.data);
                check("res_tag", res_tag, cur.tag);
                check("run_cycles", run_cycles, cur.cyc);
                check("core_rst_at_result", core_rst, cur.err);
                check("decrypt_mode", decrypt, cur.dec);
                check("serial_key", key_rx, cur.key);
                check("serial_nonce", nonce_rx, cur.nonce);
                check("serial_ad", ad_rx, cur.ad);
                check("serial_data", din_rx, cur.din);
                check("load_cycles", load_cycles, 128);
                check("crst_cycles", crst_len, 2);
            end
        end
        if (res_valid && res_ready && have_cur) begin
            check("held_res_data", res_data, cur.data);
            check("held_res_err", res_err, cur.err);
        end
        prev_v = res_valid;
    end

    // ---------------- stimulus ----------------
    task automatic push_exp(input logic err, input logic dec, input logic [Y-1:0] data,
                            input logic [127:0] tag, input logic [31:0] cyc,
                            input logic [127:0] key, input logic [127:0] nonce,
                            input logic [L-1:0] ad, input logic [Y-1:0] din);
        exp_t e;
        e.err = err; e.dec = dec; e.data = data; e.tag = tag; e.cyc = cyc;
        e.key = key; e.nonce = nonce;
        e.ad  = {ad, {(128-L){1'b0}}};
        e.din = {din, {(128-Y){1'b0}}};
        sb.push_back(e);
    endtask

    task automatic send(input logic dec, input logic [127:0] key, input logic [127:0] nonce,
                        input logic [L-1:0] ad, input logic [Y-1:0] din);
        int t = 0;
        while (!cmd_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_ready_wait: got cmd_ready=0 after %0d cycles, required 1", t);
        end
        cmd_valid = 1'b1; cmd_decrypt = dec; cmd_key = key;
        cmd_nonce = nonce; cmd_ad = ad; cmd_data = din;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        int t = 0;
        while (!res_valid && t < 3000) begin
            @(negedge clk);
            t++;
        end
        ok = res_valid;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL res_valid_wait: got res_valid=0 after %0d cycles, required 1", t);
        end
    endtask

    task automatic consume(input int hold);
        bit ok;
        wait_valid(ok);
        if (ok) begin
            repeat (hold) @(negedge clk);
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
        end
    endtask

    task automatic check_reset_vals(input string nm);
        check({nm, "_ctrl"},
              {cmd_ready, core_rst, keyxSI, noncexSI, associated_dataxSI, input_dataxSI,
               ascon_startxSI, decrypt, res_valid, res_err, busy}, 128'b11000000000);
        check({nm, "_res_data"}, res_data, '0);
        check({nm, "_res_tag"}, res_tag, '0);
        check({nm, "_run_cycles"}, run_cycles, '0);
    endtask

    initial begin
        logic [127:0] skey, snonce;
        logic [L-1:0] sad;
        logic [Y-1:0] sdin;
        int acc0;
        int t;
        bit ok;

        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // encrypt, then decrypt of the resulting ciphertext
        push_exp(1'b0, 1'b0, CT_V, TAG_V, 32'(START_LEN + LAT + 1), KEY_V, NONCE_V, AD_V, PT_V);
        send(1'b0, KEY_V, NONCE_V, AD_V, PT_V);
        consume(3);
        push_exp(1'b0, 1'b1, PT_V, TAG_V, 32'(START_LEN + LAT + 1), KEY_V, NONCE_V, AD_V, CT_V);
        send(1'b1, KEY_V, NONCE_V, AD_V, CT_V);
        consume(2);

        // serial ordering: key 80..01 sets only LOAD bits 0 and 127
        skey   = 128'h80000000000000000000000000000001;
        snonce = 128'h0123456789abcdeffedcba9876543210;
        sad    = 40'hc3000000a5;
        sdin   = 104'hf0000000000000000000000001;
        push_exp(1'b0, 1'b0, sdin ^ KS_V, skey ^ snonce ^ {sad, 88'b0},
                 32'(START_LEN + LAT + 1), skey, snonce, sad, sdin);
        send(1'b0, skey, snonce, sad, sdin);
        consume(1);

        // watchdog: core never raises ready
        no_ready = 1'b1;
        push_exp(1'b1, 1'b0, '0, '0, 32'(START_LEN + TIMEOUT), KEY_V, NONCE_V, AD_V, PT_V);
        send(1'b0, KEY_V, NONCE_V, AD_V, PT_V);
        consume(2);
        no_ready = 1'b0;

        // reset in the middle of LOAD (bit index 50)
        send(1'b1, KEY_V, NONCE_V, AD_V, CT_V);
        t = 0;
        while (!(lcnt == 51 && loading && !core_rst) && t < 500) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 500) begin
            checks++;
            errors++;
            $display("FAIL load50_wait: got lcnt=%0d, required 51", lcnt);
        end
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("midload_reset");
        rst = 1'b0;
        @(negedge clk);
        push_exp(1'b0, 1'b0, CT_V, TAG_V, 32'(START_LEN + LAT + 1), KEY_V, NONCE_V, AD_V, PT_V);
        send(1'b0, KEY_V, NONCE_V, AD_V, PT_V);
        consume(0);

        // cmd_valid held high, res_ready pulsed in the DONE entry cycle
        acc0 = accepts;
        cmd_valid = 1'b1; cmd_decrypt = 1'b0; cmd_key = KEY_V;
        cmd_nonce = NONCE_V; cmd_ad = AD_V; cmd_data = PT_V;
        push_exp(1'b0, 1'b0, CT_V, TAG_V, 32'(START_LEN + LAT + 1), KEY_V, NONCE_V, AD_V, PT_V);
        wait_valid(ok);
        push_exp(1'b0, 1'b0, CT_V, TAG_V, 32'(START_LEN + LAT + 1), KEY_V, NONCE_V, AD_V, PT_V);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        consume(0);
        repeat (3) @(negedge clk);
        check("accepts_held_valid", 128'(accepts - acc0), 128'd2);

        check("cmd_ready_vs_busy_violations", 128'(ready_busy_viol), 128'd0);
        check("scoreboard_left", 128'(sb.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got simulation still running, required completion");
        $fatal(1, "global timeout");
    end
endmodule

// File: doc/ascon_serial_ctrl.md
# ascon_serial_ctrl

Command sequencer for the bit-serial ASCON-128 core inside the user project. It accepts one parallel encrypt or decrypt command and resets the core. It then shifts key, nonce, associated data and input data into the core MSB-first, pulses start and waits for ready with a watchdog. Finally it deserialises the output data and tag back into parallel registers for the host-side wrapper.

## Interface
Parameters:
- `K`, 128, key width in bits
- `L`, 40, associated-data width in bits
- `Y`, 104, input/output data width in bits
- `START_LEN`, 3, cycles `ascon_startxSI` is held high
- `TIMEOUT`, 4096, maximum cycles spent waiting for ready
- Derived: `LOAD_LEN = max(K,128,L,Y)`, `CAP_LEN = max(Y,128)`

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  high only in IDLE
- `cmd_decrypt`  in  1  0 = encrypt, 1 = decrypt
- `cmd_key`  in  K  key
- `cmd_nonce`  in  128  nonce
- `cmd_ad`  in  L  associated data
- `cmd_data`  in  Y  plaintext or ciphertext
- `res_valid`  out  1  result available
- `res_ready`  in  1  result consumed
- `res_err`  out  1  watchdog expired
- `res_data`  out  Y  ciphertext or plaintext
- `res_tag`  out  128  tag
- `run_cycles`  out  32  cycles from first start-high cycle to ready seen
- `busy`  out  1  state ≠ IDLE
- `core_rst`  out  1  core reset
- `keyxSI`, `noncexSI`, `associated_dataxSI`, `input_dataxSI`  out  1 each  serial inputs
- `ascon_startxSI`  out  1  start
- `decrypt`  out  1  mode to core
- `output_dataxSO`, `tagxSO`, `ascon_readyxSO`  in  1 each  core outputs

## Operation
- States: IDLE → CRST → LOAD → START → WAIT → SKIP → CAP → DONE → IDLE. WAIT goes to ERR on timeout, and ERR → IDLE.
- IDLE: `cmd_valid && cmd_ready` registers all `cmd_*` fields and drives `decrypt` = `cmd_decrypt`. State → CRST.
- CRST: `core_rst` = 1 for exactly 2 cycles.
- LOAD: `LOAD_LEN` cycles, index i = 0 .. `LOAD_LEN`-1.
  - `keyxSI` = key[K-1-i] when i<K, else 0.
  - `noncexSI` = nonce[127-i].
  - `input_dataxSI` = data[Y-1-i] when i<Y, else 0.
  - `associated_dataxSI` = ad[L-1-i] when i<L, else 0.
- START: `ascon_startxSI` = 1 for `START_LEN` cycles. Serial inputs = 0.
- WAIT: `ascon_readyxSO` is sampled each cycle and ignored in every other state. The first high sample moves to SKIP.
- SKIP: 2 cycles, no action.
- CAP: `CAP_LEN` cycles, capture index j.
  - `res_data[Y-1-j]` ← `output_dataxSO` when j<Y.
  - `res_tag[127-j]` ← `tagxSO`.
  - Both are MSB-first, mirroring the load order.
- DONE: `res_valid` = 1 and `res_err` = 0. Outputs are held until `res_ready`, then state → IDLE.
- ERR: entered when the WAIT cycle count reaches `TIMEOUT`.
  - `res_valid` = 1, `res_err` = 1, `res_data` = 0, `res_tag` = 0.
  - `core_rst` = 1 while in ERR.
  - `res_ready` → IDLE.
- `run_cycles` clears on command acceptance and increments every cycle in START and WAIT. It freezes on leaving WAIT and saturates at 2^32-1.
- `cmd_valid` while not in IDLE is ignored.

## Timing
- Reset values: state IDLE, `cmd_ready` 1, `core_rst` 1, all serial inputs 0, `ascon_startxSI` 0, `decrypt` 0, `res_valid` 0, `res_err` 0, `res_data` 0, `res_tag` 0, `run_cycles` 0, `busy` 0.
- Reset asserted mid-operation returns every output to these values on the next clock edge. No partial result is emitted.
- All core-side outputs are registered. Bit i of LOAD appears in the i-th cycle after CRST ends.
- Acceptance edge at cycle 0:
  - CRST occupies cycles 1–2.
  - LOAD occupies cycles 3 .. 2+`LOAD_LEN`.
  - START occupies the next `START_LEN` cycles.
- Ready sampled high in cycle r: SKIP is r+1 and r+2, CAP starts at r+3 and takes `CAP_LEN` cycles. DONE is entered the cycle after the last capture.
- `res_ready` in the same cycle `res_valid` rises counts as consumption. `cmd_ready` rises the following cycle, so there is no same-cycle accept.
- `res_ready` while not in DONE or ERR has no effect.
- `core_rst` = 0 in every state except CRST, ERR and reset.

## Test plan
- Encrypt, default parameters. Key 6d4f8bbf60ec05a07b201d4e5b2119ac, nonce 05885e606e1271b8d47a74c7b297a318, AD 4153434f4e, PT 6173636f6e2d756e6963617373, all through the core model. Required: `res_data` = 18490112f8d5867a830748390b, `res_err` = 0, `res_valid` held until `res_ready`.
- Decrypt the same vector with CT 18490112f8d5867a830748390b. Required: `res_data` = 6173636f6e2d756e6963617373 and `res_tag` equal to the encrypt tag.
- Serial-order check with a stub core. Key 80…01 must produce `keyxSI` = 1 on LOAD cycle 0 and on cycle 127, 0 elsewhere. `associated_dataxSI` must be 0 for i ≥ 40.
- Ready never asserted with `TIMEOUT` = 16. Required: ERR after exactly 16 WAIT cycles, `res_err` = 1, data and tag = 0, `core_rst` = 1.
- Pulse `rst` during LOAD cycle 50. Required: reset values next cycle. A new command then completes normally.
- `cmd_valid` held high through the run while `res_ready` pulses in the DONE entry cycle. Required: exactly one command accepted per idle window, and `cmd_ready` = 0 throughout busy.
